// File: rtl/lift_scheduler.sv
// rtl/lift_scheduler.sv - four-floor lift controller with SCAN ordering and a shared move/door counter
module lift_scheduler #(
  parameter int MOVE_CYCLES = 4,
  parameter int DOOR_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic [1:0] req_floor,
  output logic       gndF,
  output logic       fstF,
  output logic       sndF,
  output logic       trdF,
  output logic [1:0] cur_floor,
  output logic       moving,
  output logic       dir_up,
  output logic       door_open,
  output logic [3:0] pending
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MOVE = 2'd1,
    S_DOOR = 2'd2
  } state_t;

  localparam logic [7:0] MOVE_LOAD = 8'(MOVE_CYCLES - 1);
  localparam logic [7:0] DOOR_LOAD = 8'(DOOR_CYCLES - 1);

  state_t     state_q, state_d;
  logic [1:0] floor_q, floor_d;
  logic [3:0] pending_q, pending_d;
  logic       dir_up_q, dir_up_d;
  logic [7:0] cnt_q, cnt_d;

  logic [1:0] next_floor;
  logic [3:0] clr_mask;
  logic [3:0] set_mask;
  logic       ahead_up;
  logic       ahead_down;
  logic       further;
  logic       hold_door;

  function automatic logic [3:0] onehot(input logic [1:0] f);
    return 4'b0001 << f;
  endfunction

  function automatic logic [3:0] above(input logic [1:0] f);
    return 4'b1110 << f;
  endfunction

  function automatic logic [3:0] below(input logic [1:0] f);
    return (4'b0001 << f) - 4'b0001;
  endfunction

  always_comb begin
    state_d    = state_q;
    floor_d    = floor_q;
    dir_up_d   = dir_up_q;
    cnt_d      = cnt_q;
    clr_mask   = 4'b0000;
    ahead_up   = |(pending_q & above(floor_q));
    ahead_down = |(pending_q & below(floor_q));
    next_floor = dir_up_q ? floor_q + 2'd1 : floor_q - 2'd1;
    further    = dir_up_q ? |(pending_q & above(next_floor))
                          : |(pending_q & below(next_floor));
    hold_door  = req_valid && (state_q == S_DOOR) && (req_floor == floor_q);

    case (state_q)
      S_IDLE: begin
        if (pending_q[floor_q]) begin
          state_d  = S_DOOR;
          clr_mask = onehot(floor_q);
          cnt_d    = DOOR_LOAD;
        end else if (|pending_q) begin
          state_d  = S_MOVE;
          cnt_d    = MOVE_LOAD;
          // SCAN: keep heading while work lies ahead, otherwise turn round
          dir_up_d = dir_up_q ? ahead_up : !ahead_down;
        end
      end
      S_MOVE: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          floor_d = next_floor;
          if (pending_q[next_floor]) begin
            state_d  = S_DOOR;
            clr_mask = onehot(next_floor);
            cnt_d    = DOOR_LOAD;
          end else if (further) begin
            cnt_d = MOVE_LOAD;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DOOR: begin
        if (hold_door) begin
          cnt_d = DOOR_LOAD;
        end else if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A call for the floor being served this edge is absorbed by that service
    set_mask  = (req_valid && !hold_door) ? onehot(req_floor) : 4'b0000;
    set_mask  = set_mask & ~clr_mask;
    pending_d = (pending_q & ~clr_mask) | set_mask;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      floor_q   <= 2'd0;
      pending_q <= 4'b0000;
      dir_up_q  <= 1'b1;
      cnt_q     <= 8'd0;
    end else begin
      state_q   <= state_d;
      floor_q   <= floor_d;
      pending_q <= pending_d;
      dir_up_q  <= dir_up_d;
      cnt_q     <= cnt_d;
    end
  end

  assign gndF      = (floor_q == 2'd0);
  assign fstF      = (floor_q == 2'd1);
  assign sndF      = (floor_q == 2'd2);
  assign trdF      = (floor_q == 2'd3);
  assign cur_floor = floor_q;
  assign moving    = (state_q == S_MOVE);
  assign door_open = (state_q == S_DOOR);
  assign dir_up    = dir_up_q;
  assign pending   = pending_q;

endmodule
